// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with arbitrary (non power-of-two) depth, registered
// occupancy, programmable almost-full / almost-empty thresholds, sticky
// overflow / underflow error flags, synchronous flush and a selectable
// first-word-fall-through read mode.
//
// Parameters:
//   DATA_W   data word width in bits (>= 1)
//   DEPTH    number of entries (>= 2, any integer)
//   AF_LEVEL almost_full asserts when level >= AF_LEVEL
//   AE_LEVEL almost_empty asserts when level <= AE_LEVEL
//   FWFT     0 = registered read (1-cycle latency), 1 = first-word-fall-through
//   LVL_W    derived width of the level output
//
// Ports:
//   clk          in   clock, all logic on rising edge
//   reset        in   asynchronous, active-low reset
//   clr          in   synchronous flush, overrides push/pop
//   push         in   write request
//   din          in   write data
//   pop          in   read request
//   dout         out  read data
//   dout_valid   out  dout qualifier
//   full         out  level == DEPTH
//   empty        out  level == 0
//   almost_full  out  level >= AF_LEVEL
//   almost_empty out  level <= AE_LEVEL
//   level        out  current occupancy 0..DEPTH
//   overflow     out  sticky: push seen while full
//   underflow    out  sticky: pop seen while empty
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter  int DATA_W   = 8,
  parameter  int DEPTH    = 8,
  parameter  int AF_LEVEL = 6,
  parameter  int AE_LEVEL = 2,
  parameter  int FWFT     = 0,
  localparam int LVL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0]  PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0]  LVL_ZERO = LVL_W'(0);
  localparam logic [LVL_W-1:0]  LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_AF   = LVL_W'(AF_LEVEL);
  localparam logic [LVL_W-1:0]  LVL_AE   = LVL_W'(AE_LEVEL);
  localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(0);

  // Reject parameter sets for which the flag definitions make no sense.
  if (DEPTH < 2 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_param_err
    $error("sync_fifo_flags: need DEPTH>=2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  // Storage (intentionally not reset) and registered state.
  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [LVL_W-1:0]  level_r;
  logic              full_r;
  logic              empty_r;
  logic              af_r;
  logic              ae_r;
  logic              ovf_r;
  logic              unf_r;
  logic [DATA_W-1:0] dout_r;
  logic              dv_r;

  // Next-state signals.
  logic              wr_en_s;
  logic              rd_en_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [LVL_W-1:0]  level_nxt_s;
  logic [DATA_W-1:0] dout_nxt_s;
  logic              dv_nxt_s;

  // Pointer increment with explicit wrap so any DEPTH works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_ZERO;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  // Accept decisions; a flush cycle accepts nothing.
  always_comb begin
    wr_en_s = push & ~full_r  & ~clr;
    rd_en_s = pop  & ~empty_r & ~clr;
  end

  // Next pointer values.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_en_s) begin
      wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_en_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Next occupancy; a simultaneous accepted write and read leaves it unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({wr_en_s, rd_en_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  if (FWFT != 0) begin : g_fwft
    // Head-of-queue tracking: dout always shows the entry that would be popped next.
    always_comb begin
      dout_nxt_s = dout_r;
      dv_nxt_s   = (level_nxt_s != LVL_ZERO);
      if (wr_en_s && (empty_r || (rd_en_s && (level_r == LVL_ONE)))) begin
        // The new head is the word being written this cycle; it is not in
        // storage yet, so take it straight from din.
        dout_nxt_s = din;
      end else if (rd_en_s && (level_nxt_s != LVL_ZERO)) begin
        dout_nxt_s = mem_r[rd_ptr_nxt_s];
      end else begin
        dout_nxt_s = dout_r;
      end
    end
  end else begin : g_std
    // Registered read: load the head on an accepted pop, pulse valid for one cycle.
    always_comb begin
      dout_nxt_s = dout_r;
      dv_nxt_s   = 1'b0;
      if (rd_en_s) begin
        dout_nxt_s = mem_r[rd_ptr_r];
        dv_nxt_s   = 1'b1;
      end else begin
        dout_nxt_s = dout_r;
        dv_nxt_s   = 1'b0;
      end
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Control state, flags and read data; flags derive from the next level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      dout_r   <= DATA_ZERO;
      dv_r     <= 1'b0;
    end else if (clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      level_r  <= LVL_ZERO;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      dout_r   <= DATA_ZERO;
      dv_r     <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      level_r  <= level_nxt_s;
      full_r   <= (level_nxt_s == LVL_FULL);
      empty_r  <= (level_nxt_s == LVL_ZERO);
      af_r     <= (level_nxt_s >= LVL_AF);
      ae_r     <= (level_nxt_s <= LVL_AE);
      ovf_r    <= ovf_r | (push & full_r);
      unf_r    <= unf_r | (pop & empty_r);
      dout_r   <= dout_nxt_s;
      dv_r     <= dv_nxt_s;
    end
  end

  assign dout         = dout_r;
  assign dout_valid   = dv_r;
  assign full         = full_r;
  assign empty        = empty_r;
  assign almost_full  = af_r;
  assign almost_empty = ae_r;
  assign level        = level_r;
  assign overflow     = ovf_r;
  assign underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flags
//
// Two instances: a standard-read FIFO (DEPTH 5, AF 4, AE 1) and an FWFT FIFO
// (DEPTH 4, AF 3, AE 1). Vectors are records of inputs plus expected level and
// flags; read data of the standard instance is checked against a scoreboard
// fed from a small FIFO model, FWFT data against per-vector expectations.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flags;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // standard-mode instance signals
  logic       s_clr, s_push, s_pop;
  logic [7:0] s_din, s_dout;
  logic       s_dv, s_full, s_empty, s_af, s_ae, s_ov, s_un;
  logic [2:0] s_level;

  // FWFT instance signals
  logic       f_clr, f_push, f_pop;
  logic [7:0] f_din, f_dout;
  logic       f_dv, f_full, f_empty, f_af, f_ae, f_ov, f_un;
  logic [2:0] f_level;

  sync_fifo_flags #(.DATA_W(8), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .clr(s_clr), .push(s_push), .din(s_din), .pop(s_pop),
    .dout(s_dout), .dout_valid(s_dv), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo_flags #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .clr(f_clr), .push(f_push), .din(f_din), .pop(f_pop),
    .dout(f_dout), .dout_valid(f_dv), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ov), .underflow(f_un)
  );

  typedef struct {
    logic       sel;      // 0 = standard instance, 1 = FWFT instance
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    logic [2:0] lvl;
    logic [6:0] fl;       // {full, empty, af, ae, ov, un, dv}
    logic       chk_dout;
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] fifo_q[$];  // model contents of the standard instance
  logic [7:0] out_q[$];   // words the standard instance is due to emit
  int n_vec = 0;
  int n_err = 0;

  task automatic add(input logic sel, input logic push, input logic pop, input logic clr,
                     input logic [7:0] din, input logic [2:0] lvl, input logic [6:0] fl,
                     input logic chk, input logic [7:0] dout);
    vec_t v;
    v.sel = sel; v.push = push; v.pop = pop; v.clr = clr; v.din = din;
    v.lvl = lvl; v.fl = fl; v.chk_dout = chk; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Reference model of the standard instance: decisions use pre-edge occupancy.
  task automatic model_std(input logic push, input logic pop, input logic clr, input logic [7:0] din);
    logic rd, wr;
    if (clr) begin
      fifo_q.delete();
      out_q.delete();
    end else begin
      rd = pop && (fifo_q.size() > 0);
      wr = push && (fifo_q.size() < 5);
      if (rd) out_q.push_back(fifo_q.pop_front());
      if (wr) fifo_q.push_back(din);
    end
  endtask

  task automatic idle_all();
    s_clr = 1'b0; s_push = 1'b0; s_pop = 1'b0; s_din = 8'h00;
    f_clr = 1'b0; f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;
  endtask

  task automatic check_sb(input int idx);
    logic [7:0] e;
    if (s_dv === 1'b1) begin
      if (out_q.size() == 0) begin
        chk("sb_unexpected_valid", idx, 32'd1, 32'd0);
      end else begin
        e = out_q.pop_front();
        chk("sb_dout", idx, {24'd0, s_dout}, {24'd0, e});
      end
    end
  endtask

  initial begin
    vec_t v;
    logic [6:0] act_fl;
    logic [2:0] act_lvl;
    logic [7:0] act_dout;

    // ---------------- vector tables ----------------
    // standard instance: fill, drain
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 3'd1, 7'b0001000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h12, 3'd2, 7'b0000000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h13, 3'd3, 7'b0000000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h14, 3'd4, 7'b0010000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h15, 3'd5, 7'b1010000, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd4, 7'b0010001, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 7'b0000001, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 7'b0000001, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 7'b0001001, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101001, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 7'b0101000, 1'b1, 8'h15);
    // wrap: 12 push/pop pairs, pointers go round the 5 entries repeatedly
    for (int i = 0; i < 12; i++) begin
      add(1'b0, 1'b1, 1'b0, 1'b0, 8'h20 + 8'(i), 3'd1, 7'b0001000, 1'b0, 8'h00);
      add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101001, 1'b0, 8'h00);
    end
    // simultaneous push+pop mid-level, refill to full, push+pop on full
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 3'd1, 7'b0001000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h31, 3'd1, 7'b0001001, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h32, 3'd2, 7'b0000000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 3'd3, 7'b0000000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h34, 3'd4, 7'b0010000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b0, 1'b0, 8'h35, 3'd5, 7'b1010000, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'hAA, 3'd4, 7'b0010101, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 7'b0010100, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 7'b0000101, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 7'b0000101, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 7'b0001101, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101101, 1'b0, 8'h00);
    // pop on empty, then flush with push/pop asserted (both ignored)
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101110, 1'b0, 8'h00);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h99, 3'd0, 7'b0101000, 1'b1, 8'h00);
    // push+pop on empty: push only, underflow set
    add(1'b0, 1'b1, 1'b1, 1'b0, 8'h41, 3'd1, 7'b0001010, 1'b0, 8'h00);
    add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101011, 1'b0, 8'h00);

    // FWFT instance
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h5A, 3'd1, 7'b0001001, 1'b1, 8'h5A);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h5B, 3'd2, 7'b0000001, 1'b1, 8'h5A);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 7'b0001001, 1'b1, 8'h5B);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101000, 1'b0, 8'h00);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h60, 3'd1, 7'b0001001, 1'b1, 8'h60);
    add(1'b1, 1'b1, 1'b1, 1'b0, 8'h61, 3'd1, 7'b0001001, 1'b1, 8'h61);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h62, 3'd2, 7'b0000001, 1'b1, 8'h61);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h63, 3'd3, 7'b0010001, 1'b1, 8'h61);
    add(1'b1, 1'b1, 1'b0, 1'b0, 8'h64, 3'd4, 7'b1010001, 1'b1, 8'h61);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd3, 7'b0010001, 1'b1, 8'h62);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd2, 7'b0000001, 1'b1, 8'h63);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1, 7'b0001001, 1'b1, 8'h64);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101000, 1'b0, 8'h00);
    add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 7'b0101010, 1'b0, 8'h00);
    add(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 7'b0101000, 1'b1, 8'h00);

    // ---------------- reset state ----------------
    idle_all();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_level", -1, {29'd0, s_level}, 32'd0);
    chk("rst_s_flags", -1, {25'd0, s_full, s_empty, s_af, s_ae, s_ov, s_un, s_dv}, {25'd0, 7'b0101000});
    chk("rst_s_dout",  -1, {24'd0, s_dout}, 32'd0);
    chk("rst_f_level", -1, {29'd0, f_level}, 32'd0);
    chk("rst_f_flags", -1, {25'd0, f_full, f_empty, f_af, f_ae, f_ov, f_un, f_dv}, {25'd0, 7'b0101000});
    chk("rst_f_dout",  -1, {24'd0, f_dout}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- table loop ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      idle_all();
      if (v.sel == 1'b0) begin
        s_push = v.push; s_pop = v.pop; s_clr = v.clr; s_din = v.din;
        model_std(v.push, v.pop, v.clr, v.din);
      end else begin
        f_push = v.push; f_pop = v.pop; f_clr = v.clr; f_din = v.din;
      end
      @(posedge clk);
      #1;
      if (v.sel == 1'b0) begin
        act_lvl  = s_level;
        act_fl   = {s_full, s_empty, s_af, s_ae, s_ov, s_un, s_dv};
        act_dout = s_dout;
        check_sb(i);
      end else begin
        act_lvl  = f_level;
        act_fl   = {f_full, f_empty, f_af, f_ae, f_ov, f_un, f_dv};
        act_dout = f_dout;
      end
      chk("level", i, {29'd0, act_lvl}, {29'd0, v.lvl});
      chk("flags{full,empty,af,ae,ov,un,dv}", i, {25'd0, act_fl}, {25'd0, v.fl});
      if (v.chk_dout) chk("dout", i, {24'd0, act_dout}, {24'd0, v.dout});
    end
    idle_all();

    // ---------------- async reset mid-burst ----------------
    s_push = 1'b1; s_din = 8'h71;
    @(posedge clk); #1;
    s_din = 8'h72;
    @(posedge clk); #1;
    s_din = 8'h73;
    @(posedge clk); #1;
    s_push = 1'b0;
    chk("burst_level", 100, {29'd0, s_level}, 32'd3);
    chk("burst_dout_held", 100, {24'd0, s_dout}, 32'h41);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_level", 101, {29'd0, s_level}, 32'd0);
    chk("arst_empty", 101, {31'd0, s_empty}, 32'd1);
    chk("arst_full",  101, {31'd0, s_full}, 32'd0);
    chk("arst_dout",  101, {24'd0, s_dout}, 32'd0);
    chk("arst_dv",    101, {31'd0, s_dv}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    fifo_q.delete();
    out_q.delete();
    @(posedge clk); #1;
    s_push = 1'b1; s_din = 8'h77;
    @(posedge clk); #1;
    s_push = 1'b0; s_pop = 1'b1;
    chk("post_rst_level", 102, {29'd0, s_level}, 32'd1);
    @(posedge clk); #1;
    s_pop = 1'b0;
    chk("post_rst_dv",   103, {31'd0, s_dv}, 32'd1);
    chk("post_rst_dout", 103, {24'd0, s_dout}, 32'h77);
    chk("post_rst_empty", 103, {31'd0, s_empty}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
